// File: rtl/restoring_divider_32bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with the
// trial subtraction done on a ripple-carry adder (Rs + ~D + 1).
module restoring_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             msb_s;
  logic [WIDTH-1:0] rs_s;
  logic [WIDTH-1:0] qs_s;
  logic [WIDTH-1:0] t_s;
  logic             cout_s;
  logic [WIDTH-1:0] new_q_s;
  logic [WIDTH-1:0] new_r_s;

  function automatic logic [WIDTH:0] rca_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
    logic             c;
    logic [WIDTH-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  // msb shifted out of R counts as an extra 2^WIDTH, so it forces the subtract
  assign msb_s            = r_q[WIDTH-1];
  assign rs_s             = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign qs_s             = {q_q[WIDTH-2:0], 1'b0};
  assign {cout_s, t_s}    = rca_add(rs_s, ~d_q, 1'b1);
  assign new_r_s          = (msb_s | cout_s) ? t_s : rs_s;
  assign new_q_s          = {qs_s[WIDTH-1:1], msb_s | cout_s};

  // Next-state, datapath and result-register updates
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = CW'(WIDTH);
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = S_FINISH;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        q_d   = new_q_s;
        r_d   = new_r_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FINISH;
          quot_d  = new_q_s;
          rem_d   = new_r_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, shadow and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_32bit.sv
// Directed-table and randomized checks of the restoring divider, including
// handshake, ignored-start and asynchronous reset corner cases.
module tb_restoring_divider_32bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total;
  int bad;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t vecs [8];

  restoring_divider_32bit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .ready      (ready),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Starts one division at a negedge and watches the following cycles.
  // inj_k >= 0 pulses an extra start (9/3) at that cycle of the busy period.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int inj_k, input string name);
    int w;
    int lat;
    int dones;
    int rdy_busy;
    logic rdy_after;
    int exp_lat;
    w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_ready_wait"}, {31'd0, ready}, 32'd1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat       = -1;
    dones     = 0;
    rdy_busy  = 0;
    rdy_after = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (done) begin
        dones++;
        if (lat < 0) lat = k;
      end
      if (lat < 0 && ready) rdy_busy++;
      if (lat >= 0 && k == lat + 1) rdy_after = ready;
      if (lat >= 0 && k >= lat + 2) break;
      if (k == inj_k) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    exp_lat = ez ? 1 : 33;
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_done_count"}, 32'(dones), 32'd1);
    chk({name, "_ready_busy"}, 32'(rdy_busy), 32'd0);
    chk({name, "_ready_after"}, {31'd0, rdy_after}, 32'd1);
    chk({name, "_quotient"}, quotient, eq);
    chk({name, "_remainder"}, remainder, er);
    chk({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rq;
    logic [31:0] rr;
    logic        rz;

    total = 0;
    bad   = 0;

    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  q: 32'd1,          r: 32'h7FFF_FFFF,  z: 1'b0};
    vecs[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          z: 1'b0};
    vecs[4] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          z: 1'b1};
    vecs[5] = '{a: 32'd1000,       b: 32'd3,          q: 32'd333,        r: 32'd1,          z: 1'b0};
    vecs[6] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          z: 1'b0};
    vecs[7] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1, $sformatf("vec%0d", i));
    end

    run_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 10, "ignored_start");

    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, -1, "dbz_before_reset");

    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, ready}, 32'd1);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_remainder", remainder, 32'd0);
    chk("async_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_div(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, -1, "after_reset");

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case (i % 5)
        0: rb = $urandom;
        1: rb = 32'd1;
        2: rb = ra;
        3: begin
          ra = $urandom_range(0, 1000);
          rb = $urandom | 32'h8000_0000;
        end
        default: rb = $urandom_range(1, 255);
      endcase
      if (rb == 32'd0) begin
        rq = 32'hFFFF_FFFF;
        rr = ra;
        rz = 1'b1;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
        rz = 1'b0;
      end
      run_div(ra, rb, rq, rr, rz, -1, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
